// File: rtl/coreuart_baud_ctrl.sv
// Run-time baud reconfiguration controller for the CoreUART baud clock generator.
// Latency: write in IDLE -> DRAIN next cycle; APPLY one cycle after TX/RX are both idle.
// Backpressure: tx_hold blocks new frames while draining; the request register holds one entry, latest write wins.
//
// Ports:
//   clk, reset_n                       system clock, synchronous active-low reset
//   cfg_wr, cfg_baud_val, cfg_fraction  one-cycle write of a new divisor/fraction
//   tx_busy, rx_busy                   frame activity from the transmitter / receiver
//   baud_clock                         16x pulse from the generator
//   baud_val, baud_val_fraction        active divisor/fraction driven to the generator
//   gen_reset_n                        synchronous active-low reset to the generator
//   tx_hold                            blocks new transmit starts
//   cfg_busy, cfg_done, cfg_forced     update status: in progress, completion pulse, applied on timeout
module coreuart_baud_ctrl #(
  parameter logic [12:0] DEFAULT_BAUD_VAL = 13'd1,
  parameter logic [2:0]  DEFAULT_FRACTION = 3'd0,
  parameter logic [15:0] DRAIN_TIMEOUT    = 16'd65535,
  parameter int unsigned RESET_HOLD       = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cfg_wr,
  input  logic [12:0] cfg_baud_val,
  input  logic [2:0]  cfg_fraction,
  input  logic        tx_busy,
  input  logic        rx_busy,
  input  logic        baud_clock,
  output logic [12:0] baud_val,
  output logic [2:0]  baud_val_fraction,
  output logic        gen_reset_n,
  output logic        tx_hold,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic        cfg_forced
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_DRAIN   = 3'd1;
  localparam logic [2:0] ST_APPLY   = 3'd2;
  localparam logic [2:0] ST_RESTART = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  localparam logic [3:0] HOLD_LAST    = 4'(RESET_HOLD - 1);
  localparam logic [1:0] RESTART_LAST = 2'd3;

  logic [2:0]  state;
  logic [2:0]  state_nxt;

  // pend_baud/pend_frac always hold the most recent write; pend_vld marks a
  // write that arrived too late for the current pass and needs another one.
  logic        pend_vld;
  logic [12:0] pend_baud;
  logic [2:0]  pend_frac;

  logic [15:0] drain_cnt;
  logic [3:0]  hold_cnt;
  logic [1:0]  restart_cnt;

  logic [12:0] req_baud;
  logic [2:0]  req_frac;
  logic        req_same;
  logic        drain_ok;
  logic        drain_tmo;
  logic        apply_go;

  always_comb begin
    // A write in the current cycle takes priority over the stored request,
    // so a write coinciding with drain-complete is the value that gets applied.
    req_baud  = cfg_wr ? cfg_baud_val : pend_baud;
    req_frac  = cfg_wr ? cfg_fraction : pend_frac;
    req_same  = (req_baud == baud_val) && (req_frac == baud_val_fraction);
    drain_ok  = !tx_busy && !rx_busy;
    drain_tmo = (drain_cnt == DRAIN_TIMEOUT);

    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (cfg_wr || pend_vld) begin
          state_nxt = req_same ? ST_DONE : ST_DRAIN;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (drain_ok || drain_tmo) begin
          state_nxt = ST_APPLY;
        end
      end
      ST_APPLY: begin
        if (hold_cnt == HOLD_LAST) begin
          state_nxt = ST_RESTART;
        end
      end
      ST_RESTART: begin
        // Failsafe: a generator that never pulses must not wedge the update.
        if (baud_clock || (restart_cnt == RESTART_LAST)) begin
          state_nxt = ST_DONE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    apply_go = (state == ST_DRAIN) && (state_nxt == ST_APPLY);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state             <= ST_IDLE;
      baud_val          <= DEFAULT_BAUD_VAL;
      baud_val_fraction <= DEFAULT_FRACTION;
      gen_reset_n       <= 1'b0;
      pend_vld          <= 1'b0;
      pend_baud         <= DEFAULT_BAUD_VAL;
      pend_frac         <= DEFAULT_FRACTION;
      drain_cnt         <= '0;
      hold_cnt          <= '0;
      restart_cnt       <= '0;
      cfg_forced        <= 1'b0;
    end else begin
      state <= state_nxt;

      // Registered from the next state so the generator reset is glitch-free
      // and low for exactly the cycles spent in APPLY.
      gen_reset_n <= (state_nxt != ST_APPLY);

      if (cfg_wr) begin
        pend_baud <= cfg_baud_val;
        pend_frac <= cfg_fraction;
      end

      // Writes during DRAIN fold into the current pass; writes after the
      // values were loaded queue one more pass, which DONE consumes.
      pend_vld <= (cfg_wr && ((state == ST_APPLY) || (state == ST_RESTART))) ||
                  (pend_vld && (state != ST_DONE));

      if ((state_nxt == ST_DRAIN) && (state != ST_DRAIN)) begin
        drain_cnt <= '0;
      end else if ((state == ST_DRAIN) && (drain_cnt != 16'hFFFF)) begin
        drain_cnt <= drain_cnt + 16'd1;
      end

      if (state == ST_APPLY) begin
        hold_cnt <= hold_cnt + 4'd1;
      end else begin
        hold_cnt <= '0;
      end

      if (state == ST_RESTART) begin
        restart_cnt <= restart_cnt + 2'd1;
      end else begin
        restart_cnt <= '0;
      end

      if (cfg_wr) begin
        cfg_forced <= 1'b0;
      end

      if (apply_go) begin
        baud_val          <= req_baud;
        baud_val_fraction <= req_frac;
        // A clean drain in the timeout cycle still counts as a clean drain.
        if (!drain_ok) begin
          cfg_forced <= 1'b1;
        end
      end
    end
  end

  assign tx_hold  = (state == ST_DRAIN) || (state == ST_APPLY) || (state == ST_RESTART);
  assign cfg_busy = (state != ST_IDLE) || pend_vld;
  assign cfg_done = (state == ST_DONE);

endmodule

// File: doc/coreuart_baud_ctrl.md
# coreuart_baud_ctrl

Run-time baud reconfiguration controller for the CoreUART baud clock generator. It accepts new divisor/fraction settings from the register interface and holds off new transmissions. It waits for both transmit and receive to go idle, or for a bounded timeout, then loads the new values into the generator and restarts it from a clean count. It sits between the APB/register block and the baud clock generator and owns the generator's `baud_val`, `BAUD_VAL_FRACTION` and reset inputs.

## Interface
- `DEFAULT_BAUD_VAL`, 13'd1, divisor value driven after reset
- `DEFAULT_FRACTION`, 3'd0, fraction value driven after reset
- `DRAIN_TIMEOUT`, 16'd65535, maximum DRAIN cycles before the update is forced; must be ≥1
- `RESET_HOLD`, 2, cycles `gen_reset_n` is held low in APPLY; range 1–15
- `clk` in 1: system clock
- `reset_n` in 1: reset, synchronous, active-low
- `cfg_wr` in 1: one-cycle write strobe for a new setting
- `cfg_baud_val` in 13: requested divisor, sampled when `cfg_wr`=1
- `cfg_fraction` in 3: requested fraction, sampled when `cfg_wr`=1
- `tx_busy` in 1: transmitter shifting a frame
- `rx_busy` in 1: receiver inside a frame (start bit detected, stop bit not yet sampled)
- `baud_clock` in 1: 16x pulse from the generator
- `baud_val` out 13: divisor to the generator
- `baud_val_fraction` out 3: fraction to the generator
- `gen_reset_n` out 1: synchronous active-low reset to the generator
- `tx_hold` out 1: blocks new transmit starts; a frame already in progress completes
- `cfg_busy` out 1: update in progress or pending
- `cfg_done` out 1: one-cycle pulse when an update completes
- `cfg_forced` out 1: sticky flag, set when an update was applied on timeout; cleared by the next `cfg_wr`

## Operation
- States: IDLE, DRAIN, APPLY, RESTART, DONE.
- **IDLE**
  - On `cfg_wr`, the request is latched into the pending registers.
  - If the request equals the active `baud_val`/`baud_val_fraction`: go to DONE. No generator reset and no hold.
  - Otherwise go to DRAIN and clear the drain counter.
- **DRAIN**
  - `tx_hold`=1.
  - When `tx_busy`=0 and `rx_busy`=0 are sampled in the same cycle, go to APPLY.
  - When the drain counter reaches `DRAIN_TIMEOUT`, set `cfg_forced` and go to APPLY.
- **APPLY**
  - Load the pending values into `baud_val`/`baud_val_fraction` on entry.
  - Drive `gen_reset_n`=0 for exactly `RESET_HOLD` cycles, then go to RESTART.
- **RESTART**
  - `gen_reset_n`=1.
  - Wait for `baud_clock`=1, then go to DONE.
  - Failsafe: after 4 cycles with no `baud_clock`, go to DONE anyway.
- **DONE**
  - `cfg_done`=1 for this single cycle.
  - If a newer pending request exists, go to DRAIN (or straight back to DONE if that request matches the active values). Otherwise go to IDLE.
- **Pending requests:** single-entry pending register; the latest write wins.
  - A `cfg_wr` in DRAIN overwrites the pending values and continues the same drain without restarting the timeout counter.
  - A `cfg_wr` in APPLY, RESTART or DONE is queued for one more pass.
- **Outputs:**
  - `cfg_busy`=1 whenever the state is not IDLE, or a request is pending.
  - `tx_hold`=1 in DRAIN, APPLY and RESTART.
  - `baud_val` and `baud_val_fraction` change only on entry to APPLY, never in any other state.

## Timing
- **Reset:**
  - State = IDLE; `baud_val`=`DEFAULT_BAUD_VAL`; `baud_val_fraction`=`DEFAULT_FRACTION`.
  - `gen_reset_n`=0 while `reset_n`=0, and 1 from the first cycle after `reset_n` deasserts.
  - `tx_hold`=0, `cfg_busy`=0, `cfg_done`=0, `cfg_forced`=0.
  - Pending request is cleared.
- **Reset mid-update:** `reset_n`=0 in any state aborts the update. All outputs return to their reset values, including the defaults on `baud_val`/`baud_val_fraction`.
- **Latency:**
  - `cfg_wr` at cycle N in IDLE: DRAIN at N+1 (`tx_hold`=1 and `cfg_busy`=1 at N+1).
  - Busy signals low at N+1: APPLY at N+2, with `gen_reset_n` low for cycles N+2 … N+1+`RESET_HOLD`.
  - Generator's first `baud_clock` arrives within 2 cycles after release; `cfg_done` follows 1 cycle after `baud_clock` is sampled.
- **Same-value write:** `cfg_done` at N+1 and `cfg_busy`=1 for that single cycle only; `tx_hold` stays 0.
- **Simultaneous events:**
  - `cfg_wr` in the same cycle as the drain-complete condition: APPLY uses the new values.
  - Timeout and drain-complete in the same cycle: treated as drain-complete, so `cfg_forced` is not set.
- **Drain counter:** width 16 bits; saturates and does not wrap.

## Test plan
- Reset; `tx_busy`=`rx_busy`=0; `cfg_wr` with 13'd26/3'd0 → `gen_reset_n` low for 2 cycles starting at N+2; `baud_val`=26; `cfg_done` pulse; `cfg_forced`=0.
- `tx_busy` held high for 100 cycles after `cfg_wr` → `tx_hold`=1 throughout; APPLY 1 cycle after `tx_busy` falls; `baud_val` unchanged until then.
- `DRAIN_TIMEOUT`=50; `rx_busy` stuck at 1 → APPLY entered at the timeout; `cfg_forced`=1 after the update; the next `cfg_wr` clears it.
- Write 13'd10, then 13'd40 during DRAIN, then 13'd7 during RESTART → first applied value 40, a second pass applies 7; 2 `cfg_done` pulses in total; 10 never appears on `baud_val`.
- Write equal to the active values (`DEFAULT_BAUD_VAL`/`DEFAULT_FRACTION`) → `cfg_done` at N+1; no `gen_reset_n` low; `tx_hold` stays 0.
- `reset_n` asserted during APPLY → next cycle `baud_val`=`DEFAULT_BAUD_VAL`, state IDLE, `cfg_busy`=0, `gen_reset_n`=0 until `reset_n` deasserts.
